// File: rtl/aes_pkg.sv
// Shared AES definitions: widths, FSM state type, GF((2^4)^2) helpers for the
// composite-field inverse S-box, and the FIPS-197 inverse S-box table.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_BYTE_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } inv_sb_state_e;

  function automatic logic [3:0] squarer(input logic [3:0] x);
    return {x[3], x[3] ^ x[2], x[2] ^ x[1], x[3] ^ x[1] ^ x[0]};
  endfunction

  function automatic logic [3:0] mult_lambda(input logic [3:0] x);
    return {x[2] ^ x[0], x[3] ^ x[2] ^ x[1] ^ x[0], x[3], x[2]};
  endfunction

  function automatic logic [1:0] mult_gf2(input logic [1:0] a, input logic [1:0] b);
    return {(a[1] & b[1]) ^ (a[0] & b[1]) ^ (a[1] & b[0]), (a[1] & b[1]) ^ (a[0] & b[0])};
  endfunction

  function automatic logic [1:0] mult_phi(input logic [1:0] x);
    return {x[1] ^ x[0], x[1]};
  endfunction

  // GF(2^4) product built from three GF(2^2) products (Karatsuba form).
  function automatic logic [3:0] mult_gf2_4(input logic [3:0] q, input logic [3:0] w);
    logic [1:0] hh;
    logic [1:0] ll;
    logic [1:0] mid;
    hh  = mult_gf2(q[3:2], w[3:2]);
    ll  = mult_gf2(q[1:0], w[1:0]);
    mid = mult_gf2(q[3:2] ^ q[1:0], w[3:2] ^ w[1:0]);
    return {mid ^ ll, ll ^ mult_phi(hh)};
  endfunction

  function automatic logic [3:0] mult_inv_gf2_4(input logic [3:0] x);
    logic [3:0] q;
    q[3] = x[3] ^ (x[3] & x[2] & x[1]) ^ (x[3] & x[0]) ^ x[2];
    q[2] = (x[3] & x[2] & x[1]) ^ (x[3] & x[2] & x[0]) ^ (x[3] & x[0]) ^ x[2] ^ (x[2] & x[1]);
    q[1] = x[3] ^ (x[3] & x[2] & x[1]) ^ (x[3] & x[1] & x[0]) ^ x[2] ^ (x[2] & x[0]) ^ x[1];
    q[0] = (x[3] & x[2] & x[1]) ^ (x[3] & x[2] & x[0]) ^ (x[3] & x[1]) ^ (x[3] & x[1] & x[0])
         ^ (x[3] & x[0]) ^ x[2] ^ (x[2] & x[1]) ^ (x[2] & x[1] & x[0]) ^ x[1] ^ x[0];
    return q;
  endfunction

  function automatic logic [7:0] iso_map(input logic [7:0] x);
    logic [7:0] q;
    q[7] = x[7] ^ x[5];
    q[6] = x[7] ^ x[6] ^ x[4] ^ x[3] ^ x[2] ^ x[1];
    q[5] = x[7] ^ x[5] ^ x[3] ^ x[2];
    q[4] = x[7] ^ x[5] ^ x[3] ^ x[2] ^ x[1];
    q[3] = x[7] ^ x[6] ^ x[2] ^ x[1];
    q[2] = x[7] ^ x[4] ^ x[3] ^ x[2] ^ x[1];
    q[1] = x[6] ^ x[4] ^ x[1];
    q[0] = x[6] ^ x[1] ^ x[0];
    return q;
  endfunction

  function automatic logic [7:0] inv_iso_map(input logic [7:0] x);
    logic [7:0] q;
    q[7] = x[7] ^ x[6] ^ x[5] ^ x[1];
    q[6] = x[6] ^ x[2];
    q[5] = x[6] ^ x[5] ^ x[1];
    q[4] = x[6] ^ x[5] ^ x[4] ^ x[2] ^ x[1];
    q[3] = x[5] ^ x[4] ^ x[3] ^ x[2] ^ x[1];
    q[2] = x[7] ^ x[4] ^ x[3] ^ x[2] ^ x[1];
    q[1] = x[5] ^ x[4];
    q[0] = x[6] ^ x[5] ^ x[4] ^ x[2] ^ x[0];
    return q;
  endfunction

  // Inverse of the S-box affine transform, including its 0x63 constant.
  function automatic logic [7:0] inv_affine(input logic [7:0] x);
    logic [7:0] b;
    b[0] = ~(x[2] ^ x[5] ^ x[7]);
    b[1] = x[3] ^ x[6] ^ x[0];
    b[2] = ~(x[4] ^ x[7] ^ x[1]);
    b[3] = x[5] ^ x[0] ^ x[2];
    b[4] = x[6] ^ x[1] ^ x[3];
    b[5] = x[7] ^ x[2] ^ x[4];
    b[6] = x[0] ^ x[3] ^ x[5];
    b[7] = x[1] ^ x[4] ^ x[6];
    return b;
  endfunction

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box. INV_SUBBYTE_LUT_EN selects a 256-entry table;
// otherwise the inverse is computed in the composite field GF((2^4)^2).
module inv_sbox
  import aes_pkg::*;
(
  input  logic [AES_BYTE_W-1:0] in_byte,
  output logic [AES_BYTE_W-1:0] out_byte
);

`ifdef INV_SUBBYTE_LUT_EN
  assign out_byte = INV_SBOX[in_byte];
`else
  logic [7:0] a_s;
  logic [3:0] ah_s;
  logic [3:0] al_s;
  logic [3:0] d_s;
  logic [3:0] dinv_s;

  // (ah*x + al)^-1 = ah*d^-1 * x + (ah^al)*d^-1 with d = lambda*ah^2 + al*(ah^al).
  always_comb begin
    a_s      = iso_map(inv_affine(in_byte));
    ah_s     = a_s[7:4];
    al_s     = a_s[3:0];
    d_s      = mult_lambda(squarer(ah_s)) ^ mult_gf2_4(ah_s ^ al_s, al_s);
    dinv_s   = mult_inv_gf2_4(d_s);
    out_byte = inv_iso_map({mult_gf2_4(ah_s, dinv_s), mult_gf2_4(ah_s ^ al_s, dinv_s)});
  end
`endif

endmodule

// File: rtl/inv_sub_byte_seq.sv
// Iterative AES InvSubBytes: a bank of BYTES_PER_CYCLE inverse S-boxes sweeps the
// 128-bit state one chunk per cycle. Build macro INV_SUBBYTE_LUT_EN picks LUT S-boxes.
module inv_sub_byte_seq
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [AES_BLOCK_W-1:0] invsubbyte_data_in,
  input  logic                   invsubbyte_valid_in,
  output logic                   invsubbyte_ready_out,
  output logic [AES_BLOCK_W-1:0] invsubbyte_data_out,
  output logic                   invsubbyte_valid_out,
  input  logic                   invsubbyte_ready_in
);

  localparam int NCHUNK  = 16 / BYTES_PER_CYCLE;
  localparam int CHUNK_W = BYTES_PER_CYCLE * AES_BYTE_W;
  localparam int CNT_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [AES_BLOCK_W-1:0] CHUNK_MASK = AES_BLOCK_W'({CHUNK_W{1'b1}});

  inv_sb_state_e          state_q, state_d;
  logic [AES_BLOCK_W-1:0] work_q, work_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   valid_q, valid_d;
  logic                   ready_out_s;
  logic                   last_chunk_s;
  logic [7:0]             chunk_shift_s;
  logic [CHUNK_W-1:0]     chunk_in_s;
  logic [CHUNK_W-1:0]     chunk_out_s;
  logic [AES_BLOCK_W-1:0] work_upd_s;

  for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_sbox
    inv_sbox u_inv_sbox (
      .in_byte (chunk_in_s[g*AES_BYTE_W +: AES_BYTE_W]),
      .out_byte(chunk_out_s[g*AES_BYTE_W +: AES_BYTE_W])
    );
  end

  // Route the active chunk through the S-box bank and merge the result back in place.
  always_comb begin
    chunk_shift_s = 8'(cnt_q) * 8'(CHUNK_W);
    chunk_in_s    = CHUNK_W'(work_q >> chunk_shift_s);
    work_upd_s    = (work_q & ~(CHUNK_MASK << chunk_shift_s))
                  | (AES_BLOCK_W'(chunk_out_s) << chunk_shift_s);
    last_chunk_s  = (cnt_q == CNT_W'(NCHUNK - 1));
  end

  // Next-state logic for the IDLE/BUSY/DONE handshake controller.
  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    valid_d     = valid_q;
    ready_out_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_out_s = 1'b1;
        if (invsubbyte_valid_in) begin
          work_d  = invsubbyte_data_in;
          cnt_d   = CNT_W'(0);
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        work_d = work_upd_s;
        if (last_chunk_s) begin
          valid_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        // Downstream acceptance frees the slot, so a new block can load in the same edge.
        ready_out_s = invsubbyte_ready_in;
        if (invsubbyte_ready_in) begin
          valid_d = 1'b0;
          if (invsubbyte_valid_in) begin
            work_d  = invsubbyte_data_in;
            cnt_d   = CNT_W'(0);
            state_d = ST_BUSY;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_W'(0);
        valid_d = 1'b0;
      end
    endcase
  end

  // State, work register and output flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      work_q  <= {AES_BLOCK_W{1'b0}};
      cnt_q   <= CNT_W'(0);
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign invsubbyte_ready_out = ready_out_s;
  assign invsubbyte_data_out  = work_q;
  assign invsubbyte_valid_out = valid_q;

endmodule

// File: tb/tb_inv_sub_byte_seq.sv
// Self-checking bench for inv_sub_byte_seq; reference InvSbox is computed from
// GF(2^8) arithmetic (inverse affine map, then x^254).
module tb_inv_sub_byte_seq;

  localparam int BPC    = 4;
  localparam int NCHUNK = 16 / BPC;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] data_in;
  logic         valid_in;
  logic         ready_out;
  logic [127:0] data_out;
  logic         valid_out;
  logic         ready_in;

  int checks = 0;
  int errors = 0;
  logic [7:0] ref_inv [256];

  inv_sub_byte_seq #(.BYTES_PER_CYCLE(BPC)) dut (
    .clk                 (clk),
    .reset               (reset),
    .invsubbyte_data_in  (data_in),
    .invsubbyte_valid_in (valid_in),
    .invsubbyte_ready_out(ready_out),
    .invsubbyte_data_out (data_out),
    .invsubbyte_valid_out(valid_out),
    .invsubbyte_ready_in (ready_in)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int k);
    return (x << k) | (x >> (8 - k));
  endfunction

  function automatic logic [7:0] ref_inv_sbox(input logic [7:0] x);
    logic [7:0] b;
    logic [7:0] r;
    b = rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, b);
    return r;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] x);
    logic [127:0] y;
    for (int i = 0; i < 16; i++) y[i*8 +: 8] = ref_inv[x[i*8 +: 8]];
    return y;
  endfunction

  function automatic logic [127:0] fwd(input logic [127:0] x);
    logic [127:0] y;
    y = 128'h0;
    for (int i = 0; i < 16; i++)
      for (int v = 0; v < 256; v++)
        if (ref_inv[v] == x[i*8 +: 8]) y[i*8 +: 8] = 8'(v);
    return y;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!valid_out && lat < 64) begin
      step();
      lat++;
    end
  endtask

  // One block from IDLE: handshake, garbage offered while busy, optional DONE stall.
  task automatic xfer(input logic [127:0] din, input logic [127:0] exp, input string tag, input int stall);
    int lat;
    data_in = din; valid_in = 1'b1; ready_in = 1'b0;
    step();
    data_in = ~din;
    check({tag, "_busy_rdy"}, 128'(ready_out), 128'(0));
    wait_valid(lat);
    check({tag, "_latency"}, 128'(lat), 128'(NCHUNK + 1));
    check({tag, "_data"}, data_out, exp);
    for (int s = 0; s < stall; s++) begin
      step();
      check({tag, "_hold"}, {valid_out, ready_out, data_out[125:0]}, {1'b1, 1'b0, exp[125:0]});
    end
    valid_in = 1'b0; ready_in = 1'b1;
    step();
    check({tag, "_idle"}, {126'(0), valid_out, ready_out}, 128'b01);
  endtask

  initial begin
    logic [127:0] din;
    int lat;
    for (int v = 0; v < 256; v++) ref_inv[v] = ref_inv_sbox(8'(v));

    reset = 1'b1; valid_in = 1'b0; ready_in = 1'b1; data_in = 128'h0;
    step(); step();
    reset = 1'b0;
    check("rst_valid", 128'(valid_out), 128'(0));
    check("rst_data", data_out, 128'h0);
    check("rst_ready", 128'(ready_out), 128'(1));

    xfer({16{8'h63}}, {16{8'h00}}, "b63", 0);
    xfer({16{8'h7c}}, {16{8'h01}}, "b7c", 0);
    xfer({16{8'h00}}, {16{8'h52}}, "b00", 0);
    xfer({16{8'h16}}, model({16{8'h16}}), "b16", 1);
    xfer(128'hd42711aee0bf98f1b8b45de51e415230, 128'h193de3bea0f4e22b9ac68d2ae9f84808, "fips", 0);

    // Backpressure for 10 cycles, then a zero-bubble reload.
    din = 128'hd42711aee0bf98f1b8b45de51e415230;
    xfer(din, model(din), "bp", 10);
    data_in = din; valid_in = 1'b1; ready_in = 1'b0;
    step();
    wait_valid(lat);
    check("bp2_latency", 128'(lat), 128'(NCHUNK + 1));
    din = {$urandom, $urandom, $urandom, $urandom};
    data_in = din; ready_in = 1'b1;
    step();
    check("b2b_no_idle", {126'(0), valid_out, ready_out}, 128'b00);
    valid_in = 1'b0; ready_in = 1'b0;
    wait_valid(lat);
    check("b2b_latency", 128'(lat), 128'(NCHUNK + 1));
    check("b2b_data", data_out, model(din));
    ready_in = 1'b1;
    step();

    // Reset during the second BUSY cycle.
    data_in = {$urandom, $urandom, $urandom, $urandom}; valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst", {data_out, valid_out, ready_out} == {128'h0, 1'b0, 1'b1} ? 128'(1) : 128'(0), 128'(1));
    din = {$urandom, $urandom, $urandom, $urandom};
    xfer(din, model(din), "post_rst", 0);

    xfer(fwd(128'h5847088b15b61cba59d4e2e8cd39dfce), 128'h5847088b15b61cba59d4e2e8cd39dfce, "roundtrip", 0);

    for (int v = 0; v < 256; v++) begin
      for (int i = 0; i < 16; i++) din[i*8 +: 8] = 8'(v + i);
      xfer(din, model(din), "sweep", 0);
    end

    for (int n = 0; n < 40; n++) begin
      din = {$urandom, $urandom, $urandom, $urandom};
      xfer(din, model(din), "rand", int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
